// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the SDRAM bus between I-cache and D-cache engines.
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
   parameter int ADDRW   = 32,
   parameter int TIMEOUT = 255,
   parameter int TOW     = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             IReq,
   input  logic             IRW,
   input  logic [3:0]       IBE,
   input  logic [ADDRW-1:0] IAddress,
   output logic             IGrant,
   output logic             ITxD,
   output logic             IRxD,
   input  logic             DReq,
   input  logic             DRW,
   input  logic [3:0]       DBE,
   input  logic [ADDRW-1:0] DAddress,
   output logic             DGrant,
   output logic             DTxD,
   output logic             DRxD,
   output logic             MStrobe,
   output logic             MRW,
   output logic [3:0]       MBE,
   output logic [ADDRW-1:0] MAddress,
   input  logic             MDone,
   input  logic             mSDR_TxD,
   input  logic             mSDR_RxD,
   output logic             Timeout,
   output logic [1:0]       o_dbg_state
);

   // Handshake: a cache holds xReq until it sees xGrant; the transaction
   // starts with the one-cycle MStrobe and ends on the one-cycle MDone pulse.

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_BUSY    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   if (TIMEOUT >= (1 << TOW)) begin : g_bad_timeout
      $error("mem_bus_arbiter: TIMEOUT must fit in TOW bits");
   end

   state_t r_state;
   state_t w_state_nxt;
   logic   r_own_i;
   logic   r_own_d;
   logic   r_last_d;
   logic   w_pick_d;
   logic   w_active;
   logic   w_igrant;
   logic   w_dgrant;
   logic   w_timeout_hit;

   // On a tie the port that did not own the bus last time wins.
   assign w_pick_d = DReq & (~IReq | ~r_last_d);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (IReq | DReq) w_state_nxt = ST_GRANT;
         ST_GRANT:   w_state_nxt = MDone ? ST_RELEASE : ST_BUSY;
         ST_BUSY:    if (MDone | w_timeout_hit) w_state_nxt = ST_RELEASE;
         ST_RELEASE: w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_own_i  <= 1'b0;
         r_own_d  <= 1'b0;
         r_last_d <= 1'b0;
      end else if (r_state == ST_IDLE && (IReq | DReq)) begin
         r_own_i <= ~w_pick_d;
         r_own_d <= w_pick_d;
      end else if (r_state == ST_RELEASE) begin
         r_last_d <= r_own_d;
         r_own_i  <= 1'b0;
         r_own_d  <= 1'b0;
      end
   end

`ifdef ARB_TIMEOUT_EN
   logic [TOW-1:0] r_cnt;
   logic [TOW-1:0] w_cnt_inc;
   logic           r_timeout;

   // The BUSY cycle whose incremented count reaches TIMEOUT is the last one.
   assign w_cnt_inc     = r_cnt + TOW'(1);
   assign w_timeout_hit = (r_state == ST_BUSY) && !MDone && (w_cnt_inc == TOW'(TIMEOUT));

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state == ST_GRANT) begin
            r_cnt <= '0;
         end else if (r_state == ST_BUSY) begin
            r_cnt <= w_cnt_inc;
         end
         if (w_timeout_hit) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign Timeout = r_timeout;
`else
   assign w_timeout_hit = 1'b0;
   assign Timeout       = 1'b0;
`endif

   assign w_active = (r_state == ST_GRANT) || (r_state == ST_BUSY);
   assign w_igrant = w_active & r_own_i;
   assign w_dgrant = w_active & r_own_d;

   assign IGrant   = w_igrant;
   assign DGrant   = w_dgrant;
   assign MStrobe  = (r_state == ST_GRANT);
   assign MRW      = (w_igrant & IRW) | (w_dgrant & DRW);
   assign MBE      = ({4{w_igrant}} & IBE) | ({4{w_dgrant}} & DBE);
   assign MAddress = ({ADDRW{w_igrant}} & IAddress) | ({ADDRW{w_dgrant}} & DAddress);

   assign ITxD = mSDR_TxD & w_igrant;
   assign IRxD = mSDR_RxD & w_igrant;
   assign DTxD = mSDR_TxD & w_dgrant;
   assign DRxD = mSDR_RxD & w_dgrant;

   assign o_dbg_state = r_state;

endmodule
